// File: rtl/mux_scan_sequencer_pkg.sv
// Shared types and constants for the 16:1 mux scan sequencer.
// The parity feature is compiled in with MUX_SCAN_PARITY_EN.
package mux_scan_pkg;

  localparam int unsigned N_CH_C  = 16;
  localparam int unsigned SEL_W_C = 4;
  localparam int unsigned CNT_W_C = 4;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SETTLE_WAIT = 2'd1,
    SAMPLE      = 2'd2,
    DONE        = 2'd3
  } state_t;

  // Cycles from the start-accept edge to the data_valid rise.
  function automatic int unsigned scan_latency(input int unsigned settle);
    return N_CH_C * (settle + 1);
  endfunction

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Downstream word handshake of the mux scan sequencer.
// The parity_err member exists only with MUX_SCAN_PARITY_EN.
interface mux_scan_sequencer_if;
  import mux_scan_pkg::*;

  logic [N_CH_C-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
`ifdef MUX_SCAN_PARITY_EN
  logic              parity_err;

  modport master (output data_out, output data_valid, output parity_err, input data_ready);
  modport slave  (input data_out, input data_valid, input parity_err, output data_ready);
`else
  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);
`endif

endinterface

// File: rtl/mux_scan_sequencer_settle_cnt.sv
// Loadable down-counter that times the settle interval after each select change.
// It stops at zero, and done_c flags the last wait cycle.
module scan_settle_cnt
  import mux_scan_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [CNT_W_C-1:0] load_val,
  output logic               done_c
);

  logic [CNT_W_C-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W_C'(1);
    end
  end

  assign done_c = (cnt == CNT_W_C'(1));

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scans a 16:1 mux through all channels, samples each after a settle delay, and
// hands the assembled word downstream. The MUX_SCAN_PARITY_EN macro adds a parity check.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int unsigned N_CH   = N_CH_C,
  parameter int unsigned SEL_W  = SEL_W_C,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mux_f,
`ifdef MUX_SCAN_PARITY_EN
  input  logic             exp_parity,
`endif
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  mux_scan_sequencer_if.master bus
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CH - 1);
  // With no settle time, each select change goes straight back to SAMPLE.
  localparam state_t AFTER_SEL = (SETTLE == 0) ? SAMPLE : SETTLE_WAIT;

  state_t          state;
  logic [N_CH-1:0] cap;
  logic [N_CH-1:0] cap_nxt_c;
  logic            load_c;
  logic            settle_done_c;
`ifdef MUX_SCAN_PARITY_EN
  logic            exp_par_q;
`endif

  always_comb begin
    cap_nxt_c      = cap;
    cap_nxt_c[sel] = mux_f;
  end

  assign load_c = ((state == IDLE) && start) || ((state == SAMPLE) && (sel != LAST_SEL));

  scan_settle_cnt u_settle_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (load_c),
    .load_val (CNT_W_C'(SETTLE)),
    .done_c   (settle_done_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      sel            <= '0;
      busy           <= 1'b0;
      cap            <= '0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      bus.parity_err <= 1'b0;
      exp_par_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sel   <= '0;
            busy  <= 1'b1;
            cap   <= '0;
            state <= AFTER_SEL;
`ifdef MUX_SCAN_PARITY_EN
            exp_par_q <= exp_parity;
`endif
          end
        end
        SETTLE_WAIT: begin
          if (settle_done_c) state <= SAMPLE;
        end
        SAMPLE: begin
          cap <= cap_nxt_c;
          if (sel == LAST_SEL) begin
            bus.data_out   <= cap_nxt_c;
            bus.data_valid <= 1'b1;
            state          <= DONE;
`ifdef MUX_SCAN_PARITY_EN
            bus.parity_err <= (^cap_nxt_c) != exp_par_q;
`endif
          end else begin
            sel   <= sel + SEL_W'(1);
            state <= AFTER_SEL;
          end
        end
        DONE: begin
          // Word and select stay frozen until the downstream takes the word.
          if (bus.data_ready) begin
            bus.data_valid <= 1'b0;
            busy           <= 1'b0;
            state          <= IDLE;
`ifdef MUX_SCAN_PARITY_EN
            bus.parity_err <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Randomized self-checking bench: two sequencers (SETTLE=1 and SETTLE=0) scan a behavioural mux.
// The expected word is the pattern the mux presents, and the select trace follows t/(SETTLE+1).
module tb_mux_scan_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst0, start1, start0;
  logic [15:0] w1, w0;
  logic        ovr1, ovr_val1;
  logic        mux_f1, mux_f0;
  logic [3:0]  sel1, sel0;
  logic        busy1, busy0;
`ifdef MUX_SCAN_PARITY_EN
  logic        exp_par1, exp_par0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int trace_sel [256];
  logic trace_busy [256];

  // Behavioural 16:1 mux: channel i presents pattern bit i.
  assign mux_f1 = ovr1 ? ovr_val1 : w1[sel1];
  assign mux_f0 = w0[sel0];

  mux_scan_sequencer_if bus1 ();
  mux_scan_sequencer_if bus0 ();

  mux_scan_sequencer #(.SETTLE(1)) u_s1 (
    .clk   (clk),
    .reset (rst1),
    .start (start1),
    .mux_f (mux_f1),
`ifdef MUX_SCAN_PARITY_EN
    .exp_parity (exp_par1),
`endif
    .sel   (sel1),
    .busy  (busy1),
    .bus   (bus1.master)
  );

  mux_scan_sequencer #(.SETTLE(0)) u_s0 (
    .clk   (clk),
    .reset (rst0),
    .start (start0),
    .mux_f (mux_f0),
`ifdef MUX_SCAN_PARITY_EN
    .exp_parity (exp_par0),
`endif
    .sel   (sel0),
    .busy  (busy0),
    .bus   (bus0.master)
  );

  // Pulse start (caller is at a negedge) and record sel/busy until data_valid.
  task automatic run_scan(input int which, input logic [15:0] w, output int lat);
    if (which == 0) begin w1 = w; start1 = 1'b1; end
    else            begin w0 = w; start0 = 1'b1; end
    @(negedge clk);
    start1 = 1'b0;
    start0 = 1'b0;
    lat = 0;
    while (!((which == 0) ? bus1.data_valid : bus0.data_valid) && lat < 200) begin
      trace_sel[lat]  = (which == 0) ? int'(sel1) : int'(sel0);
      trace_busy[lat] = (which == 0) ? busy1 : busy0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake(input int which);
    if (which == 0) bus1.data_ready = 1'b1; else bus0.data_ready = 1'b1;
    @(negedge clk);
    bus1.data_ready = 1'b0;
    bus0.data_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst1 = 1'b1; rst0 = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (sel1 !== 4'd0) begin n_err++; $display("FAIL reset_sel1: got %0d want 0", sel1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL reset_busy1: got %b want 0", busy1); end
    n_cmp++; if (bus1.data_out !== 16'h0) begin n_err++; $display("FAIL reset_data1: got %h want 0000", bus1.data_out); end
    n_cmp++; if (bus1.data_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid1: got %b want 0", bus1.data_valid); end
    n_cmp++; if (sel0 !== 4'd0) begin n_err++; $display("FAIL reset_sel0: got %0d want 0", sel0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy0: got %b want 0", busy0); end
    n_cmp++; if (bus0.data_out !== 16'h0) begin n_err++; $display("FAIL reset_data0: got %h want 0000", bus0.data_out); end
    n_cmp++; if (bus0.data_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid0: got %b want 0", bus0.data_valid); end
    rst1 = 1'b0; rst0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_settle1_scan;
    logic [15:0] w;
    int lat, bad_sel, bad_busy;
    for (int k = 0; k < 4; k++) begin
      w = (k == 0) ? 16'hA5C3 : 16'($urandom);
      run_scan(0, w, lat);
      bad_sel = 0; bad_busy = 0;
      for (int t = 0; t < lat; t++) begin
        if (trace_sel[t] != t / 2) bad_sel++;
        if (trace_busy[t] !== 1'b1) bad_busy++;
      end
      n_cmp++; if (lat !== 16 * 2) begin n_err++; $display("FAIL s1_latency[%0d]: got %0d want %0d", k, lat, 16 * 2); end
      n_cmp++; if (bus1.data_out !== w) begin n_err++; $display("FAIL s1_data[%0d]: got %h want %h", k, bus1.data_out, w); end
      n_cmp++; if (bad_sel !== 0) begin n_err++; $display("FAIL s1_sel_trace[%0d]: got %0d wrong cycles want 0", k, bad_sel); end
      n_cmp++; if (bad_busy !== 0) begin n_err++; $display("FAIL s1_busy_trace[%0d]: got %0d low cycles want 0", k, bad_busy); end
      n_cmp++; if (sel1 !== 4'd15) begin n_err++; $display("FAIL s1_done_sel[%0d]: got %0d want 15", k, sel1); end
      handshake(0);
      n_cmp++; if (bus1.data_valid !== 1'b0) begin n_err++; $display("FAIL s1_hs_valid[%0d]: got %b want 0", k, bus1.data_valid); end
      n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL s1_hs_busy[%0d]: got %b want 0", k, busy1); end
      n_cmp++; if (sel1 !== 4'd15) begin n_err++; $display("FAIL s1_idle_sel[%0d]: got %0d want 15", k, sel1); end
    end
  endtask

  task automatic test_settle0_scan;
    logic [15:0] pats [2];
    int lat, bad_sel;
    pats[0] = 16'hFFFF;
    pats[1] = 16'h0001;
    for (int k = 0; k < 2; k++) begin
      run_scan(1, pats[k], lat);
      bad_sel = 0;
      for (int t = 0; t < lat; t++) if (trace_sel[t] != t) bad_sel++;
      n_cmp++; if (lat !== 16) begin n_err++; $display("FAIL s0_latency[%0d]: got %0d want 16", k, lat); end
      n_cmp++; if (trace_busy[0] !== 1'b1) begin n_err++; $display("FAIL s0_accept[%0d]: got busy %b want 1", k, trace_busy[0]); end
      n_cmp++; if (bus0.data_out !== pats[k]) begin n_err++; $display("FAIL s0_data[%0d]: got %h want %h", k, bus0.data_out, pats[k]); end
      n_cmp++; if (bad_sel !== 0) begin n_err++; $display("FAIL s0_sel_trace[%0d]: got %0d wrong cycles want 0", k, bad_sel); end
      handshake(1);
      n_cmp++; if (bus0.data_valid !== 1'b0) begin n_err++; $display("FAIL s0_hs_valid[%0d]: got %b want 0", k, bus0.data_valid); end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] w;
    int lat, bad;
    w = 16'($urandom);
    run_scan(0, w, lat);
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL bp_latency: got %0d want 32", lat); end
    ovr1 = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      start1   = 1'b1;
      ovr_val1 = 1'($urandom);
      @(negedge clk);
      if (bus1.data_out !== w || bus1.data_valid !== 1'b1 || busy1 !== 1'b1 || sel1 !== 4'd15) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL bp_hold: got %0d disturbed cycles want 0", bad); end
    n_cmp++; if (bus1.data_out !== w) begin n_err++; $display("FAIL bp_data: got %h want %h", bus1.data_out, w); end
    start1 = 1'b0;
    ovr1   = 1'b0;
    handshake(0);
    @(negedge clk);
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL bp_no_queue: got busy %b want 0", busy1); end
    n_cmp++; if (bus1.data_valid !== 1'b0) begin n_err++; $display("FAIL bp_valid_after: got %b want 0", bus1.data_valid); end
  endtask

  task automatic test_reset_mid_scan;
    logic [15:0] w;
    int k, lat;
    w1 = 16'($urandom);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    k = 0;
    while (sel1 !== 4'd7 && k < 40) begin @(negedge clk); k++; end
    n_cmp++; if (k >= 40) begin n_err++; $display("FAIL rst_reach_sel7: got timeout want sel 7"); end
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    n_cmp++; if (sel1 !== 4'd0) begin n_err++; $display("FAIL rst_mid_sel: got %0d want 0", sel1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", busy1); end
    n_cmp++; if (bus1.data_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", bus1.data_valid); end
    n_cmp++; if (bus1.data_out !== 16'h0) begin n_err++; $display("FAIL rst_mid_data: got %h want 0000", bus1.data_out); end
    repeat (3) @(negedge clk);
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL rst_no_resume: got busy %b want 0", busy1); end
    w = 16'($urandom);
    run_scan(0, w, lat);
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL rst_rescan_latency: got %0d want 32", lat); end
    n_cmp++; if (bus1.data_out !== w) begin n_err++; $display("FAIL rst_rescan_data: got %h want %h", bus1.data_out, w); end
    handshake(0);
  endtask

  task automatic test_back_to_back;
    logic [15:0] q [$];
    logic [15:0] exp_w;
    int cyc, last, nvalid;
    w1 = 16'($urandom);
    q.push_back(w1);
    start1 = 1'b1;
    bus1.data_ready = 1'b1;
    cyc = 0; last = 0; nvalid = 0;
    while (nvalid < 4 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus1.data_valid === 1'b1) begin
        exp_w = q.pop_front();
        n_cmp++; if (bus1.data_out !== exp_w) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", nvalid, bus1.data_out, exp_w); end
        if (nvalid == 0) begin
          n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL b2b_first: got cycle %0d want 33", cyc); end
        end else begin
          n_cmp++; if (cyc - last !== 34) begin n_err++; $display("FAIL b2b_period[%0d]: got %0d want 34", nvalid, cyc - last); end
        end
        last = cyc;
        nvalid++;
        if (nvalid < 4) begin
          w1 = 16'($urandom);
          q.push_back(w1);
        end else begin
          start1 = 1'b0;
        end
      end
    end
    n_cmp++; if (nvalid !== 4) begin n_err++; $display("FAIL b2b_count: got %0d scans want 4", nvalid); end
    start1 = 1'b0;
    @(negedge clk);
    bus1.data_ready = 1'b0;
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL b2b_end_busy: got %b want 0", busy1); end
  endtask

`ifdef MUX_SCAN_PARITY_EN
  task automatic test_parity;
    int lat;
    for (int k = 0; k < 2; k++) begin
      exp_par1 = 1'(k);
      run_scan(0, 16'h0007, lat);
      n_cmp++; if (bus1.parity_err !== 1'(1 - k)) begin n_err++; $display("FAIL parity_err[%0d]: got %b want %b", k, bus1.parity_err, 1'(1 - k)); end
      handshake(0);
      n_cmp++; if (bus1.parity_err !== 1'b0) begin n_err++; $display("FAIL parity_clear[%0d]: got %b want 0", k, bus1.parity_err); end
    end
  endtask
`endif

  initial begin
    rst1 = 1'b1; rst0 = 1'b1;
    start1 = 1'b0; start0 = 1'b0;
    w1 = 16'h0; w0 = 16'h0;
    ovr1 = 1'b0; ovr_val1 = 1'b0;
    bus1.data_ready = 1'b0;
    bus0.data_ready = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
    exp_par1 = 1'b0; exp_par0 = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_settle1_scan();
    test_settle0_scan();
    test_backpressure();
    test_reset_mid_scan();
    test_back_to_back();
`ifdef MUX_SCAN_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
